// File: rtl/ram_write_ctrl.sv
// ============================================================================
// Module   : ram_write_ctrl
// Purpose  : Button-driven cursor and frame-RAM writer (paint one cell / sweep-clear).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_write_ctrl #(
    parameter int                GRID_W          = 4,
    parameter int                GRID_H          = 4,
    parameter int                ADDR_W          = 4,
    parameter int                DATA_W          = 32,
    parameter int                DEBOUNCE_CYCLES = 250000,
    parameter int                BTN_ACTIVE_LOW  = 1,
    parameter logic [DATA_W-1:0] PAINT_COLOR     = DATA_W'(32'h00FFFFFF),
    parameter logic [DATA_W-1:0] CLEAR_COLOR     = DATA_W'(32'h00000000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              switch,
    input  logic [2:0]        btn,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [9:0]        cur_x,
    output logic [9:0]        cur_y,
    output logic              busy
);

    localparam int              CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      c_BTN_REL    = (BTN_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;
    localparam logic [ADDR_W-1:0] c_X_LAST   = ADDR_W'(GRID_W - 1);
    localparam logic [ADDR_W-1:0] c_Y_LAST   = ADDR_W'(GRID_H - 1);
    localparam logic [ADDR_W-1:0] c_GRID_W_A = ADDR_W'(GRID_W);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PAINT = 2'd1;
    localparam logic [1:0] c_ST_CLEAR = 2'd2;

    logic [2:0]        r_btn_s1;
    logic [2:0]        r_btn_s2;
    logic              r_sw_s1;
    logic              r_sw_s2;
    logic [2:0]        w_btn_pressed;
    logic [2:0]        w_press;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_cur_x;
    logic [ADDR_W-1:0] r_cur_y;
    logic [ADDR_W-1:0] w_cx_nxt;
    logic [ADDR_W-1:0] w_cy_nxt;
    logic [ADDR_W-1:0] w_cur_addr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_busy;
    logic              w_wr_en_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_busy_nxt;

    // Sync flops keep raw polarity so their reset value is "released".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_s1 <= c_BTN_REL;
            r_btn_s2 <= c_BTN_REL;
            r_sw_s1  <= 1'b0;
            r_sw_s2  <= 1'b0;
        end else begin
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= switch;
            r_sw_s2  <= r_sw_s1;
        end
    end

    assign w_btn_pressed = r_btn_s2 ^ c_BTN_REL;

    for (genvar i = 0; i < 3; i++) begin : g_debounce
        logic             r_db;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_db  <= 1'b0;
                r_cnt <= '0;
            end else if (w_btn_pressed[i] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_db  <= w_btn_pressed[i];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        // Pulse in the cycle the debounced level flips to pressed.
        assign w_press[i] = w_btn_pressed[i] & ~r_db & (r_cnt == c_CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_press[2]) begin
                    w_state_nxt = r_sw_s2 ? c_ST_CLEAR : c_ST_PAINT;
                end
            end
            c_ST_PAINT: w_state_nxt = c_ST_IDLE;
            c_ST_CLEAR: begin
                if (r_wr_addr == c_LAST_ADDR) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Moves are applied before the action so a paint uses the updated cursor.
    always_comb begin
        w_cx_nxt    = r_cur_x;
        w_cy_nxt    = r_cur_y;
        w_wr_en_nxt = 1'b0;
        w_addr_nxt  = r_wr_addr;
        w_data_nxt  = r_wr_data;
        w_busy_nxt  = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (w_press[0]) begin
                w_cx_nxt = (r_cur_x == c_X_LAST) ? '0 : r_cur_x + ADDR_W'(1);
            end
            if (w_press[1]) begin
                w_cy_nxt = (r_cur_y == c_Y_LAST) ? '0 : r_cur_y + ADDR_W'(1);
            end
        end
        w_cur_addr = w_cy_nxt * c_GRID_W_A + w_cx_nxt;
        case (w_state_nxt)
            c_ST_PAINT: begin
                w_wr_en_nxt = 1'b1;
                w_addr_nxt  = w_cur_addr;
                w_data_nxt  = PAINT_COLOR;
            end
            c_ST_CLEAR: begin
                w_wr_en_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
                w_addr_nxt  = (r_state == c_ST_CLEAR) ? r_wr_addr + ADDR_W'(1) : '0;
                w_data_nxt  = CLEAR_COLOR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur_x   <= '0;
            r_cur_y   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_cur_x   <= w_cx_nxt;
            r_cur_y   <= w_cy_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_addr_nxt;
            r_wr_data <= w_data_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign cur_x   = 10'(r_cur_x);
    assign cur_y   = 10'(r_cur_y);

endmodule

`default_nettype wire
